// File: rtl/tx_pkg.sv
// Shared constants and types for the ultrasonic transmit path.
// Holds the LFSR polynomial, the per-sequence seed table, FSM states and the carrier LUT.
// No logic of its own; imported by tx_prbs_gen and tx_signal_generator.
package tx_pkg;

  // Carrier samples per chip: one full fs/4 carrier period.
  localparam int SAMPLES_PER_CHIP = 4;

  // x^8 + x^6 + x^5 + x^4 + 1, bit k holds the coefficient of x^k.
  localparam logic [8:0] LFSR_POLY = 9'h171;

  // Map polynomial terms onto feedback taps of a shift-right register whose
  // bit 0 is the output: term x^k taps state bit 8-k.
  function automatic logic [7:0] poly_to_taps(input logic [8:0] poly);
    logic [7:0] taps;
    taps = '0;
    for (int k = 1; k <= 8; k++) begin
      taps[8-k] = poly[k];
    end
    return taps;
  endfunction

  localparam logic [7:0] LFSR_TAPS = poly_to_taps(LFSR_POLY);

  // Seeds shared with the RX correlator reference generator; all non-zero.
  localparam logic [7:0] SEQ_SEED [16] = '{
    8'h01, 8'h1D, 8'h2B, 8'h37, 8'h4F, 8'h5A, 8'h63, 8'h7E,
    8'h85, 8'h99, 8'hA6, 8'hB3, 8'hC4, 8'hD8, 8'hE1, 8'hF7
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_GUARD = 2'd2
  } tx_state_e;

  // fs/4 carrier: {0, +amp, 0, -amp} indexed by phase.
  function automatic logic signed [15:0] carrier_lut(input logic [1:0] phase,
                                                     input logic signed [15:0] amp);
    logic signed [15:0] val;
    case (phase)
      2'd1:    val = amp;
      2'd3:    val = -amp;
      default: val = '0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/tx_prbs_gen.sv
// 8-bit Fibonacci LFSR producing one chip per step.
// Latency: load/step take effect on the next clock; chip is the registered bit 0.
// No backpressure: advances only when step is asserted.
//   clk, rst   : clock, synchronous active-high reset (state returns to 8'h01)
//   load, seed : load a new seed (a zero seed is replaced by 8'h01)
//   step       : shift once
//   chip       : current output bit
module tx_prbs_gen
  import tx_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       step,
  output logic       chip
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic       fb;

  always_comb begin
    fb     = ^(lfsr_q & LFSR_TAPS);
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (seed == 8'h00) ? 8'h01 : seed;
    end else if (step) begin
      lfsr_d = {fb, lfsr_q[7:1]};
    end
    // The all-zero state is a lock-up state; never allow it to be entered.
    if (lfsr_d == 8'h00) begin
      lfsr_d = 8'h01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 8'h01;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign chip = lfsr_q[0];

endmodule

// File: rtl/tx_signal_generator.sv
// BPSK-on-fs/4 PRBS transmit sample generator feeding the DAC.
// Latency: first sample strobe 1 clock after an accepted start, then one every SAMPLE_DIV clocks.
// No backpressure: the DAC consumes every strobe; starts while busy are dropped and flagged.
//   ctx_clk, rtx_rst              : clock, synchronous active-high reset
//   etx_en, istart_trig, iseq_sel : enable (low aborts), start pulse, sequence index
//   icurrent_time                 : time base latched as otx_time on start
//   osample/osample_valid         : signed DAC sample and its strobe
//   obusy, odone, ostart_err      : status; otx_time, oseq_sent : latched per start
module tx_signal_generator
  import tx_pkg::*;
#(
  parameter int                 SAMPLE_DIV    = 128,
  parameter int                 SEQ_LEN       = 255,
  parameter int                 GUARD_SAMPLES = 64,
  parameter logic signed [15:0] AMP           = 16'sd16384
) (
  input  logic               ctx_clk,
  input  logic               rtx_rst,
  input  logic               etx_en,
  input  logic               istart_trig,
  input  logic [3:0]         iseq_sel,
  input  logic [15:0]        icurrent_time,
  output logic signed [15:0] osample,
  output logic               osample_valid,
  output logic               obusy,
  output logic               odone,
  output logic               ostart_err,
  output logic [15:0]        otx_time,
  output logic [3:0]         oseq_sent
);

  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int GRD_W = (GUARD_SAMPLES > 1) ? $clog2(GUARD_SAMPLES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [GRD_W-1:0] GRD_LAST  = GRD_W'(GUARD_SAMPLES - 1);
  localparam logic [7:0]       CHIP_LAST = 8'(SEQ_LEN - 1);
  localparam logic [1:0]       SAMP_LAST = 2'(SAMPLES_PER_CHIP - 1);

  tx_state_e          state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [1:0]         samp_cnt_q, samp_cnt_d;
  logic [7:0]         chip_cnt_q, chip_cnt_d;
  logic [GRD_W-1:0]   guard_cnt_q, guard_cnt_d;
  logic               valid_q, valid_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [15:0]        tx_time_q, tx_time_d;
  logic [3:0]         seq_sent_q, seq_sent_d;

  logic               strobe_due;
  logic               lfsr_load;
  logic               lfsr_step;
  logic               chip;
  logic signed [15:0] carrier;

  tx_prbs_gen u_prbs (
    .clk  (ctx_clk),
    .rst  (rtx_rst),
    .load (lfsr_load),
    .seed (SEQ_SEED[iseq_sel]),
    .step (lfsr_step),
    .chip (chip)
  );

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    samp_cnt_d  = samp_cnt_q;
    chip_cnt_d  = chip_cnt_q;
    guard_cnt_d = guard_cnt_q;
    tx_time_d   = tx_time_q;
    seq_sent_d  = seq_sent_q;
    valid_d     = 1'b0;
    done_d      = 1'b0;
    lfsr_load   = 1'b0;
    lfsr_step   = 1'b0;
    strobe_due  = (div_cnt_q == DIV_LAST);
    // done_q marks the closing cycle of a transmission; a start there is still "busy".
    err_d       = istart_trig && ((state_q != ST_IDLE) || done_q);

    if (!etx_en) begin
      state_d     = ST_IDLE;
      div_cnt_d   = '0;
      samp_cnt_d  = '0;
      chip_cnt_d  = '0;
      guard_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (istart_trig && !done_q) begin
            state_d     = ST_SEND;
            tx_time_d   = icurrent_time;
            seq_sent_d  = iseq_sel;
            lfsr_load   = 1'b1;
            div_cnt_d   = '0;
            samp_cnt_d  = '0;
            chip_cnt_d  = '0;
            guard_cnt_d = '0;
            valid_d     = 1'b1;    // sample 0 goes out with the state change
          end
        end

        ST_SEND: begin
          div_cnt_d = strobe_due ? '0 : div_cnt_q + DIV_W'(1);
          if (strobe_due) begin
            valid_d = 1'b1;
            if (samp_cnt_q == SAMP_LAST) begin
              samp_cnt_d = '0;
              if (chip_cnt_q == CHIP_LAST) begin
                // This strobe is the first guard sample.
                state_d     = ST_GUARD;
                guard_cnt_d = '0;
              end else begin
                chip_cnt_d = chip_cnt_q + 8'd1;
                lfsr_step  = 1'b1;
              end
            end else begin
              samp_cnt_d = samp_cnt_q + 2'd1;
            end
          end
        end

        ST_GUARD: begin
          if (valid_q && (guard_cnt_q == GRD_LAST)) begin
            // The clock after the last guard strobe closes the transmission.
            state_d   = ST_IDLE;
            done_d    = 1'b1;
            div_cnt_d = '0;
          end else begin
            div_cnt_d = strobe_due ? '0 : div_cnt_q + DIV_W'(1);
            if (strobe_due) begin
              valid_d     = 1'b1;
              guard_cnt_d = guard_cnt_q + GRD_W'(1);
            end
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge ctx_clk) begin
    if (rtx_rst) begin
      state_q     <= ST_IDLE;
      div_cnt_q   <= '0;
      samp_cnt_q  <= '0;
      chip_cnt_q  <= '0;
      guard_cnt_q <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      tx_time_q   <= '0;
      seq_sent_q  <= '0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      samp_cnt_q  <= samp_cnt_d;
      chip_cnt_q  <= chip_cnt_d;
      guard_cnt_q <= guard_cnt_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      tx_time_q   <= tx_time_d;
      seq_sent_q  <= seq_sent_d;
    end
  end

  // osample is a function of held state only, so it is stable between strobes
  // and zero outside SEND (AMP <= 32767 keeps the negation in range).
  assign carrier       = carrier_lut(samp_cnt_q, AMP);
  assign osample       = (state_q == ST_SEND) ? (chip ? carrier : -carrier) : '0;
  assign osample_valid = valid_q;
  assign obusy         = (state_q != ST_IDLE);
  assign odone         = done_q;
  assign ostart_err    = err_q;
  assign otx_time      = tx_time_q;
  assign oseq_sent     = seq_sent_q;

endmodule

// File: tb/tb_tx_signal_generator.sv
module tb_tx_signal_generator;

  localparam int DIV    = 4;
  localparam int GRD    = 4;
  localparam int NCHIP  = 255;
  localparam int NSEND  = NCHIP * 4;
  localparam int NTOT   = NSEND + GRD;
  localparam int AMPV   = 16384;
  localparam int TX_LEN = (NTOT - 1) * DIV + 2;

  localparam logic [7:0] SEEDS [16] = '{
    8'h01, 8'h1D, 8'h2B, 8'h37, 8'h4F, 8'h5A, 8'h63, 8'h7E,
    8'h85, 8'h99, 8'hA6, 8'hB3, 8'hC4, 8'hD8, 8'hE1, 8'hF7
  };

  logic               ctx_clk = 1'b0;
  logic               rtx_rst;
  logic               etx_en;
  logic               istart_trig;
  logic [3:0]         iseq_sel;
  logic [15:0]        icurrent_time;
  logic signed [15:0] osample;
  logic               osample_valid;
  logic               obusy;
  logic               odone;
  logic               ostart_err;
  logic [15:0]        otx_time;
  logic [3:0]         oseq_sent;

  tx_signal_generator #(
    .SAMPLE_DIV    (DIV),
    .SEQ_LEN       (NCHIP),
    .GUARD_SAMPLES (GRD),
    .AMP           (16'sd16384)
  ) dut (
    .ctx_clk       (ctx_clk),
    .rtx_rst       (rtx_rst),
    .etx_en        (etx_en),
    .istart_trig   (istart_trig),
    .iseq_sel      (iseq_sel),
    .icurrent_time (icurrent_time),
    .osample       (osample),
    .osample_valid (osample_valid),
    .obusy         (obusy),
    .odone         (odone),
    .ostart_err    (ostart_err),
    .otx_time      (otx_time),
    .oseq_sent     (oseq_sent)
  );

  always #5 ctx_clk = ~ctx_clk;

  int cyc = 0;
  always @(posedge ctx_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Observation log, sampled on the falling edge.
  int   strb_v[$];
  int   strb_t[$];
  int   done_t[$];
  int   err_t[$];
  int   busy_fall_t[$];
  logic busy_prev = 1'b0;

  always @(negedge ctx_clk) begin
    if (osample_valid) begin
      strb_v.push_back(int'(osample));
      strb_t.push_back(cyc);
    end
    if (odone) done_t.push_back(cyc);
    if (ostart_err) err_t.push_back(cyc);
    if (busy_prev && !obusy) busy_fall_t.push_back(cyc);
    busy_prev = obusy;
  end

  // Reference: chip stream from the LFSR recurrence s[n+8] = s[n]^s[n+2]^s[n+3]^s[n+4]
  // (seed bit i is s[i]); each chip spans 4 carrier samples {0,+A,0,-A}, inverted for chip 0.
  int exp_v [NTOT];

  function automatic void build_model(input logic [7:0] seed);
    bit s [NCHIP + 8];
    int mag;
    for (int i = 0; i < 8; i++) s[i] = seed[i];
    for (int n = 0; n < NCHIP; n++) s[n+8] = s[n] ^ s[n+2] ^ s[n+3] ^ s[n+4];
    for (int k = 0; k < NTOT; k++) begin
      if (k >= NSEND || (k % 2) == 0) begin
        exp_v[k] = 0;
      end else begin
        mag      = ((k % 4) == 1) ? AMPV : -AMPV;
        exp_v[k] = s[k/4] ? mag : -mag;
      end
    end
  endfunction

  task automatic clear_log();
    strb_v.delete();
    strb_t.delete();
    done_t.delete();
    err_t.delete();
    busy_fall_t.delete();
  endtask

  // Drive a one-cycle start; t0 is the cycle number of the accepting edge's cycle.
  task automatic start_tx(input logic [3:0] sel, input logic [15:0] t, output int t0);
    @(negedge ctx_clk);
    clear_log();
    iseq_sel      = sel;
    icurrent_time = t;
    istart_trig   = 1'b1;
    t0            = cyc;
    @(negedge ctx_clk);
    istart_trig   = 1'b0;
    iseq_sel      = 4'($urandom);
    icurrent_time = 16'($urandom);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge ctx_clk);
      if (odone) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_strobes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge ctx_clk);
      if (strb_v.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic abort_tx();
    @(negedge ctx_clk);
    etx_en = 1'b0;
    @(negedge ctx_clk);
    etx_en = 1'b1;
    @(negedge ctx_clk);
  endtask

  task automatic test_reset();
    int  t0;
    int  n_at_release;
    rtx_rst = 1'b1; etx_en = 1'b0; istart_trig = 1'b0; iseq_sel = '0; icurrent_time = '0;
    repeat (3) @(negedge ctx_clk);
    n_checks++;
    if ({osample, osample_valid, obusy, odone, ostart_err, otx_time, oseq_sent} !== '0)
      $display("FAIL reset_por: outputs %h, expected all zero",
               {osample, osample_valid, obusy, odone, ostart_err, otx_time, oseq_sent});
    else n_pass++;
    rtx_rst = 1'b0; etx_en = 1'b1;

    start_tx(4'd5, 16'hBEEF, t0);
    repeat (60) @(negedge ctx_clk);
    n_checks++;
    if (obusy !== 1'b1) $display("FAIL reset_pre_busy: obusy=%b expected 1", obusy);
    else n_pass++;
    rtx_rst = 1'b1;
    repeat (3) @(negedge ctx_clk);
    n_checks++;
    if ({osample, osample_valid, obusy, odone, ostart_err, otx_time, oseq_sent} !== '0)
      $display("FAIL reset_mid_send: outputs %h, expected all zero",
               {osample, osample_valid, obusy, odone, ostart_err, otx_time, oseq_sent});
    else n_pass++;
    rtx_rst = 1'b0;
    n_at_release = strb_v.size();
    repeat (12) @(negedge ctx_clk);
    n_checks++;
    if (strb_v.size() != n_at_release || obusy !== 1'b0)
      $display("FAIL reset_idle_after: strobes=%0d busy=%b, expected %0d strobes busy=0",
               strb_v.size(), obusy, n_at_release);
    else n_pass++;
  endtask

  task automatic test_basic_send();
    int t0;
    bit ok;
    int bad;
    build_model(SEEDS[0]);
    start_tx(4'd0, 16'h0042, t0);
    wait_done(TX_LEN + 20, ok);
    // A start landing in the odone cycle must be refused.
    istart_trig = 1'b1;
    iseq_sel    = 4'd9;
    @(negedge ctx_clk);
    istart_trig = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL basic_done_seen: odone not seen within %0d cycles", TX_LEN + 20);
    else n_pass++;
    n_checks++;
    if (ostart_err !== 1'b1 || obusy !== 1'b0 || oseq_sent !== 4'd0)
      $display("FAIL start_at_done: err=%b busy=%b seq=%0d, expected err=1 busy=0 seq=0",
               ostart_err, obusy, oseq_sent);
    else n_pass++;
    repeat (3) @(negedge ctx_clk);

    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (strb_v.size() <= i)
        $display("FAIL basic_first%0d: no strobe, expected value %0d", i, exp_v[i]);
      else if (strb_v[i] !== exp_v[i] || strb_t[i] !== t0 + 1 + DIV * i)
        $display("FAIL basic_first%0d: value %0d at cycle %0d, expected %0d at %0d",
                 i, strb_v[i], strb_t[i], exp_v[i], t0 + 1 + DIV * i);
      else n_pass++;
    end

    n_checks++;
    if (strb_v.size() != NTOT)
      $display("FAIL basic_strobe_count: got %0d, expected %0d", strb_v.size(), NTOT);
    else n_pass++;

    bad = 0;
    for (int k = 0; k < NTOT; k++)
      if (k >= strb_v.size() || strb_v[k] !== exp_v[k]) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL basic_values: %0d mismatching samples, expected 0", bad);
    else n_pass++;

    bad = 0;
    for (int k = 1; k < strb_t.size(); k++)
      if (strb_t[k] - strb_t[k-1] != DIV) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL basic_spacing: %0d bad gaps, expected 0", bad);
    else n_pass++;

    n_checks++;
    if (done_t.size() != 1 || done_t[0] !== t0 + TX_LEN)
      $display("FAIL basic_done_time: %0d pulses first at %0d, expected 1 at %0d",
               done_t.size(), (done_t.size() > 0) ? done_t[0] : -1, t0 + TX_LEN);
    else n_pass++;

    n_checks++;
    if (busy_fall_t.size() != 1 || busy_fall_t[0] !== t0 + TX_LEN)
      $display("FAIL basic_busy_fall: %0d falls first at %0d, expected 1 at %0d",
               busy_fall_t.size(), (busy_fall_t.size() > 0) ? busy_fall_t[0] : -1, t0 + TX_LEN);
    else n_pass++;
  endtask

  task automatic test_sequence_match();
    for (int sel = 1; sel < 16; sel++) begin
      logic [15:0] ts;
      int          t0;
      bit          ok;
      int          bad;
      ts = 16'($urandom);
      build_model(SEEDS[sel]);
      start_tx(4'(sel), ts, t0);
      wait_done(TX_LEN + 20, ok);
      repeat (2) @(negedge ctx_clk);
      n_checks++;
      if (!ok) $display("FAIL seq%0d_done: odone not seen", sel);
      else n_pass++;
      bad = (strb_v.size() != NTOT) ? 1 : 0;
      for (int k = 0; k < NTOT; k++)
        if (k >= strb_v.size() || strb_v[k] !== exp_v[k]) bad++;
      n_checks++;
      if (bad != 0) $display("FAIL seq%0d_values: %0d mismatches (%0d strobes), expected 0",
                             sel, bad, strb_v.size());
      else n_pass++;
      n_checks++;
      if (oseq_sent !== 4'(sel) || otx_time !== ts)
        $display("FAIL seq%0d_latched: seq=%0d time=%h, expected seq=%0d time=%h",
                 sel, oseq_sent, otx_time, sel, ts);
      else n_pass++;
    end
  endtask

  task automatic test_start_busy();
    int t0;
    int c;
    bit ok;
    int bad;
    build_model(SEEDS[7]);
    start_tx(4'd7, 16'h7777, t0);
    wait_strobes(20, 200, ok);
    istart_trig = 1'b1;
    iseq_sel    = 4'd2;
    c           = cyc;
    @(negedge ctx_clk);
    istart_trig = 1'b0;
    repeat (5) @(negedge ctx_clk);
    n_checks++;
    if (!ok || err_t.size() != 1 || err_t[0] !== c + 1)
      $display("FAIL busy_err_pulse: %0d pulses first at %0d, expected 1 at %0d",
               err_t.size(), (err_t.size() > 0) ? err_t[0] : -1, c + 1);
    else n_pass++;
    n_checks++;
    if (oseq_sent !== 4'd7 || obusy !== 1'b1)
      $display("FAIL busy_seq_kept: seq=%0d busy=%b, expected seq=7 busy=1", oseq_sent, obusy);
    else n_pass++;
    wait_strobes(160, 1000, ok);
    bad = ok ? 0 : 1;
    for (int k = 0; k < 160; k++)
      if (k >= strb_v.size() || strb_v[k] !== exp_v[k]) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL busy_waveform: %0d mismatches, expected 0", bad);
    else n_pass++;
    abort_tx();
  endtask

  task automatic test_enable_drop();
    int t0;
    int t1;
    bit ok;
    int bad;
    build_model(SEEDS[10]);
    start_tx(4'd10, 16'h0BAD, t0);
    wait_strobes(42, 400, ok);
    etx_en = 1'b0;
    @(negedge ctx_clk);
    etx_en = 1'b1;
    n_checks++;
    if (!ok || obusy !== 1'b0 || osample_valid !== 1'b0 || osample !== 16'sd0)
      $display("FAIL drop_idle: busy=%b valid=%b sample=%0d, expected 0 0 0",
               obusy, osample_valid, osample);
    else n_pass++;
    bad = 0;
    for (int k = 0; k < 42; k++)
      if (k >= strb_v.size() || strb_v[k] !== exp_v[k]) bad++;
    n_checks++;
    if (bad != 0) $display("FAIL drop_pre_values: %0d mismatches, expected 0", bad);
    else n_pass++;
    repeat (40) @(negedge ctx_clk);
    n_checks++;
    if (done_t.size() != 0 || strb_v.size() != 42)
      $display("FAIL drop_quiet: done=%0d strobes=%0d, expected 0 and 42",
               done_t.size(), strb_v.size());
    else n_pass++;
    n_checks++;
    if (oseq_sent !== 4'd10 || otx_time !== 16'h0BAD)
      $display("FAIL drop_retained: seq=%0d time=%h, expected 10 0bad", oseq_sent, otx_time);
    else n_pass++;

    start_tx(4'd10, 16'h0C0D, t1);
    wait_strobes(60, 400, ok);
    bad = ok ? 0 : 1;
    for (int k = 0; k < 60; k++)
      if (k >= strb_v.size() || strb_v[k] !== exp_v[k]) bad++;
    n_checks++;
    if (bad != 0 || strb_t[0] !== t1 + 1)
      $display("FAIL drop_restart: %0d mismatches first strobe at %0d, expected 0 at %0d",
               bad, strb_t[0], t1 + 1);
    else n_pass++;
    abort_tx();
  endtask

  task automatic test_timestamp();
    int t0;
    build_model(SEEDS[3]);
    start_tx(4'd3, 16'h1234, t0);
    n_checks++;
    if (otx_time !== 16'h1234) $display("FAIL ts_latch: got %h expected 1234", otx_time);
    else n_pass++;
    icurrent_time = 16'h5678;
    repeat (100) @(negedge ctx_clk);
    n_checks++;
    if (otx_time !== 16'h1234) $display("FAIL ts_hold: got %h expected 1234", otx_time);
    else n_pass++;
    abort_tx();
    icurrent_time = 16'h9ABC;
    repeat (5) @(negedge ctx_clk);
    n_checks++;
    if (otx_time !== 16'h1234 || oseq_sent !== 4'd3)
      $display("FAIL ts_after: time=%h seq=%0d expected 1234 3", otx_time, oseq_sent);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_send();
    test_sequence_match();
    test_start_busy();
    test_enable_drop();
    test_timestamp();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
